multicycle_core: RTL

Parametrised successor of the single-instruction-skeleton core. It is a complete multi-cycle RV32I-subset CPU with an explicit IF/ID/EX/MEM/WB state sequence and a register file with configurable depth (RV32I or RV32E). It adds variable-latency req/ack instruction and data memory ports, branch/jump PC update, configurable exit detection and illegal-instruction halt. It sits between the top-level instruction/data memories and the testbench exit monitor.

---
 rtl/multicycle_core_pkg.sv | 157 +++++++++++++++
 rtl/multicycle_core_if.sv | 32 +++
 rtl/multicycle_core_regfile.sv | 41 ++++
 rtl/multicycle_core.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_core_pkg.sv
// Shared types, opcode constants and decode helpers
// for the multi-cycle RV32I-subset core.
package multicycle_core_pkg;

  localparam int WORD_LEN = 32;

  typedef logic [WORD_LEN-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF,
    ST_ID,
    ST_EX,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu;
    logic    use_imm;
    logic    writes_rd;
    logic    is_load;
    logic    is_store;
    logic    is_beq;
    logic    is_bne;
    logic    is_jal;
    word_t   imm;
  } ex_ctl_t;

  typedef struct packed {
    logic    valid;
    logic    uses_rs1;
    logic    uses_rs2;
    ex_ctl_t ctl;
  } dec_t;

  function automatic word_t alu_eval(
    alu_op_e op,
    word_t   a,
    word_t   b
  );
    word_t r;
    unique case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic dec_t decode(word_t i);
    dec_t       d;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    word_t      imm_i;
    word_t      imm_s;
    word_t      imm_b;
    word_t      imm_j;
    op    = i[6:0];
    f3    = i[14:12];
    f7    = i[31:25];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7],
             i[30:25], i[11:8], 1'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12],
             i[20], i[30:21], 1'b0};
    d = '0;
    unique case (1'b1)
      op == OPC_OP && f3 == F3_ADD
        && f7 == F7_BASE: begin
        d.valid = 1'b1;
      end
      op == OPC_OP && f3 == F3_ADD
        && f7 == F7_SUB: begin
        d.valid   = 1'b1;
        d.ctl.alu = ALU_SUB;
      end
      op == OPC_OP && f3 == F3_XOR
        && f7 == F7_BASE: begin
        d.valid   = 1'b1;
        d.ctl.alu = ALU_XOR;
      end
      op == OPC_OP && f3 == F3_OR
        && f7 == F7_BASE: begin
        d.valid   = 1'b1;
        d.ctl.alu = ALU_OR;
      end
      op == OPC_OP && f3 == F3_AND
        && f7 == F7_BASE: begin
        d.valid   = 1'b1;
        d.ctl.alu = ALU_AND;
      end
      op == OPC_OP_IMM && f3 == F3_ADD: d.valid = 1'b1;
      op == OPC_LOAD && f3 == F3_LW:    d.valid = 1'b1;
      op == OPC_STORE && f3 == F3_SW:   d.valid = 1'b1;
      op == OPC_BRANCH && f3 == F3_BEQ: begin
        d.valid      = 1'b1;
        d.ctl.is_beq = 1'b1;
      end
      op == OPC_BRANCH && f3 == F3_BNE: begin
        d.valid      = 1'b1;
        d.ctl.is_bne = 1'b1;
      end
      op == OPC_JAL: d.valid = 1'b1;
      default: ;
    endcase
    if (d.valid) begin
      d.uses_rs1 = op != OPC_JAL;
      d.uses_rs2 = op inside {OPC_OP, OPC_STORE,
                              OPC_BRANCH};
      d.ctl.writes_rd = op inside {OPC_OP, OPC_OP_IMM,
                                   OPC_LOAD, OPC_JAL};
      d.ctl.use_imm = op inside {OPC_OP_IMM, OPC_LOAD,
                                 OPC_STORE};
      d.ctl.is_load  = op == OPC_LOAD;
      d.ctl.is_store = op == OPC_STORE;
      d.ctl.is_jal   = op == OPC_JAL;
      d.ctl.imm = op == OPC_STORE  ? imm_s :
                  op == OPC_BRANCH ? imm_b :
                  op == OPC_JAL    ? imm_j : imm_i;
    end
    return d;
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Instruction and data memory req/ack ports
// between the core (master) and memories (slave).
interface multicycle_core_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    output dmem_req, dmem_we,
    output dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    input  dmem_req, dmem_we,
    input  dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/multicycle_core_regfile.sv
// Architectural register file: two async reads,
// one sync write, x0 hardwired to zero.
module multicycle_core_regfile
  import multicycle_core_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  output word_t      rdata1,
  output word_t      rdata2,
  input  logic       we,
  input  logic [4:0] waddr,
  input  word_t      wdata
);

  localparam int         IW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  word_t regs [NUM_REGS];

  // Indices beyond the file read as zero rather than aliasing.
  assign rdata1 = (raddr1 != '0 && {1'b0, raddr1} < NR)
                ? regs[raddr1[IW-1:0]] : '0;
  assign rdata2 = (raddr2 != '0 && {1'b0, raddr2} < NR)
                ? regs[raddr2[IW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != '0
                 && {1'b0, waddr} < NR) begin
      regs[waddr[IW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: IF/ID/EX/MEM/WB
// sequencing with req/ack memories and halt on exit/illegal.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int    NUM_REGS   = 32,
  parameter word_t START_ADDR = 32'h0000_0000,
  parameter word_t EXIT_INST  = 32'h3433_3231
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_core_if.master bus,
  output logic              exit,
  output logic              illegal,
  output word_t             pc_out
);

  localparam logic [5:0] NR = 6'(NUM_REGS);

  state_e     state;
  word_t      pc;
  word_t      inst_reg;
  word_t      rs1_val;
  word_t      rs2_val;
  word_t      alu_out;
  word_t      mem_data;
  ex_ctl_t    ctl;
  logic       taken;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;

  dec_t       dec;
  word_t      rf_rd1;
  word_t      rf_rd2;
  word_t      alu_b;
  word_t      alu_res;
  word_t      target;
  word_t      pc_next;
  word_t      rf_wdata;
  logic       bad_idx;
  logic       jump;
  logic       misalign;
  logic       rf_we;
  logic       is_mem;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign rs1_idx = inst_reg[19:15];
  assign rs2_idx = inst_reg[24:20];
  assign rd_idx  = inst_reg[11:7];
  assign dec     = decode(inst_reg);

  assign bad_idx =
    (dec.uses_rs1 && {1'b0, rs1_idx} >= NR) ||
    (dec.uses_rs2 && {1'b0, rs2_idx} >= NR) ||
    (dec.ctl.writes_rd && {1'b0, rd_idx} >= NR);

  assign alu_b    = ctl.use_imm ? ctl.imm : rs2_val;
  assign alu_res  = alu_eval(ctl.alu, rs1_val, alu_b);
  assign is_mem   = ctl.is_load | ctl.is_store;
  assign target   = pc + ctl.imm;
  assign jump     = ctl.is_jal | taken;
  assign misalign = jump && target[1:0] != 2'b00;
  assign pc_next  = jump ? target : pc + 32'd4;
  assign rf_we    = state == ST_WB && ctl.writes_rd
                 && !misalign;
  assign rf_wdata = ctl.is_load ? mem_data : alu_out;

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.dmem_addr  = alu_out;
  assign bus.dmem_wdata = rs2_val;
  assign pc_out         = pc;

  multicycle_core_regfile #(
    .NUM_REGS(NUM_REGS)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr1(rs1_idx),
    .raddr2(rs2_idx),
    .rdata1(rf_rd1),
    .rdata2(rf_rd2),
    .we    (rf_we),
    .waddr (rd_idx),
    .wdata (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= START_ADDR;
      inst_reg <= '0;
      rs1_val  <= '0;
      rs2_val  <= '0;
      alu_out  <= '0;
      mem_data <= '0;
      ctl      <= '0;
      taken    <= 1'b0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      exit     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          imem_req <= 1'b1;
          state    <= ST_IF;
        end
        ST_IF: begin
          if (imem_req && bus.imem_ack) begin
            inst_reg <= bus.imem_rdata;
            imem_req <= 1'b0;
            state    <= ST_ID;
          end
        end
        ST_ID: begin
          if (inst_reg == EXIT_INST) begin
            exit  <= 1'b1;
            state <= ST_HALT;
          end else if (!dec.valid || bad_idx) begin
            illegal <= 1'b1;
            state   <= ST_HALT;
          end else begin
            ctl     <= dec.ctl;
            rs1_val <= rf_rd1;
            rs2_val <= rf_rd2;
            state   <= ST_EX;
          end
        end
        ST_EX: begin
          alu_out <= ctl.is_jal ? pc + 32'd4 : alu_res;
          taken   <= (ctl.is_beq && rs1_val == rs2_val)
                  || (ctl.is_bne && rs1_val != rs2_val);
          if (is_mem) begin
            dmem_req <= 1'b1;
            dmem_we  <= ctl.is_store;
          end
          state <= ST_MEM;
        end
        ST_MEM: begin
          if (!is_mem) begin
            state <= ST_WB;
          end else if (dmem_req && bus.dmem_ack) begin
            if (ctl.is_load) mem_data <= bus.dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= ST_WB;
          end
        end
        ST_WB: begin
          // A misaligned target halts with pc and rd untouched.
          if (misalign) begin
            illegal <= 1'b1;
            state   <= ST_HALT;
          end else begin
            pc       <= pc_next;
            imem_req <= 1'b1;
            state    <= ST_IF;
          end
        end
        ST_HALT: ;
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule
